// File: rtl/da_lut_engine.sv
// Bit-serial distributed-arithmetic inner product y = sum c_k*x_k, using a
// run-time writable partial-sum LUT addressed by one bit of every sample.
module da_lut_engine #(
  parameter  int N_TAPS = 4,
  parameter  int IN_W   = 12,
  parameter  int COEF_W = 16,
  localparam int ACC_W  = COEF_W + IN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   cfg_we,
  input  logic [N_TAPS-1:0]      cfg_addr,
  input  logic [COEF_W-1:0]      cfg_data,
  output logic                   cfg_drop,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_TAPS*IN_W-1:0] x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       y_out
);

  localparam int            BW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [BW-1:0] B_TOP = BW'(IN_W - 1);
  localparam int            DEPTH = 2 ** N_TAPS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                rst_sync;
  logic                      rst_s_n;
  logic [BW-1:0]             bit_idx;
  logic                      accept;
  logic [N_TAPS-1:0]         lut_addr;
  logic signed [COEF_W-1:0]  lut [DEPTH];
  logic signed [ACC_W-1:0]   lut_ext;
  logic signed [ACC_W-1:0]   acc;
  logic [N_TAPS*IN_W-1:0]    x_sh;

  function automatic logic signed [ACC_W-1:0] sext_coef(input logic signed [COEF_W-1:0] v);
    return {{IN_W{v[COEF_W-1]}}, v};
  endfunction

  // Reset: asserts immediately, releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_s_n = rst_sync[1];

  assign in_ready  = rst_s_n && (state == IDLE) && en;
  assign accept    = in_ready && in_valid;
  assign out_valid = (state == DONE);
  assign y_out     = (state == DONE) ? acc : '0;

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (en && bit_idx == '0) state_nxt = DONE;
      DONE:    if (en && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      bit_idx  <= '0;
      cfg_drop <= 1'b0;
    end else begin
      cfg_drop <= cfg_we && (state != IDLE);
      if (accept)                   bit_idx <= B_TOP;
      else if (state == RUN && en)  bit_idx <= bit_idx - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (cfg_we && en && state == IDLE) begin
      lut[cfg_addr] <= cfg_data;
    end
  end

  // Address bit k is the current MSB of sample lane k
  always_comb begin
    lut_addr = '0;
    for (int k = 0; k < N_TAPS; k++) lut_addr[k] = x_sh[k*IN_W + IN_W - 1];
  end
  assign lut_ext = sext_coef(lut[lut_addr]);

  // Whole-vector shift: a lane's MSB only sees the neighbour's bits after
  // IN_W shifts, which is past the end of the run.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_sh <= x_in;
      acc  <= '0;
    end else if (state == RUN && en) begin
      x_sh <= x_sh << 1;
      if (bit_idx == B_TOP) acc <= -lut_ext;
      else                  acc <= (acc <<< 1) + lut_ext;
    end
  end

endmodule

// File: tb/tb_da_lut_engine.sv
// Randomized self-checking bench for da_lut_engine; expected results come from
// plain dot products of the coefficients the LUT was built from.
module tb_da_lut_engine;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 16;
  localparam int AW = CW + W;

  logic          clk = 1'b0;
  logic          rst_n, en, cfg_we, cfg_drop, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  cfg_addr;
  logic [CW-1:0] cfg_data;
  logic [N*W-1:0] x_in;
  logic [AW-1:0] y_out;

  int n_chk  = 0;
  int n_fail = 0;
  int c_m [N];
  int x_v [N];

  always #5 clk = ~clk;

  da_lut_engine #(.N_TAPS(N), .IN_W(W), .COEF_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_drop(cfg_drop), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint dot();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(c_m[k]) * longint'(x_v[k]);
    return s;
  endfunction

  function automatic longint y_s();
    return longint'($signed(y_out));
  endfunction

  task automatic lut_write(input int a, input int d);
    cfg_addr = a[N-1:0];
    cfg_data = d[CW-1:0];
    cfg_we   = 1'b1;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic load_coefs();
    for (int a = 0; a < 2**N; a++) begin
      int s = 0;
      for (int k = 0; k < N; k++) if (a[k]) s += c_m[k];
      lut_write(a, s);
    end
  endtask

  task automatic rand_coefs();
    for (int k = 0; k < N; k++) c_m[k] = int'($urandom_range(16383)) - 8192;
  endtask

  task automatic rand_x();
    for (int k = 0; k < N; k++) x_v[k] = int'($urandom_range(255)) - 128;
  endtask

  task automatic do_vec(input string tag, input longint exp_y, input int exp_lat,
                        input int stall_at, input int stall_len, input int cfg_at,
                        input int hold, input bit sim_we, input int sim_addr,
                        input int sim_data);
    int n = 0;
    int lat = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    for (int k = 0; k < N; k++) x_in[k*W +: W] = x_v[k][W-1:0];
    in_valid = 1'b1;
    if (sim_we) begin
      cfg_we   = 1'b1;
      cfg_addr = sim_addr[N-1:0];
      cfg_data = sim_data[CW-1:0];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    x_in     = $urandom;
    check({tag, "_ready_low"}, in_ready, 0);
    while (lat < 100) begin
      lat++;
      en = !(lat > stall_at && lat <= stall_at + stall_len);
      if (lat == cfg_at) begin
        cfg_we   = 1'b1;
        cfg_addr = N'(2**N - 1);
        cfg_data = CW'($urandom);
      end
      @(posedge clk); #1;
      if (lat == cfg_at) check({tag, "_drop"}, cfg_drop, 1);
      if (cfg_at > 0 && lat == cfg_at + 1) check({tag, "_drop_end"}, cfg_drop, 0);
      cfg_we = 1'b0;
      en     = 1'b1;
      if (out_valid) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_y"}, y_s(), exp_y);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_y"}, y_s(), exp_y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint ovr;
    int     l_new;
    rst_n = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; out_ready = 1'b0; x_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_y_out", y_out, 0);
    check("rst_cfg_drop", cfg_drop, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_edge1", in_ready, 0);
    @(posedge clk); #1;
    check("rst_ready_edge2", in_ready, 1);

    rand_x();
    do_vec("zero_lut", 0, W, 0, 0, 0, 0, 1'b0, 0, 0);

    c_m = '{1, 2, 3, 4};
    load_coefs();
    x_v = '{1, 1, 1, 1};
    do_vec("basic", 10, W, 0, 0, 0, 0, 1'b0, 0, 0);
    x_v = '{-128, 127, 0, 0};
    do_vec("signed", 126, W, 0, 0, 0, 0, 1'b0, 0, 0);

    lut_write(15, 'h8000);
    lut_write(0, 0);
    x_v = '{-128, -128, -128, -128};
    do_vec("extreme", 64'sh400000, W, 0, 0, 0, 0, 1'b0, 0, 0);

    // All-ones samples select LUT[15] on every bit: y = -LUT[15]
    l_new = int'($urandom_range(65535)) - 32768;
    x_v = '{-1, -1, -1, -1};
    do_vec("same_edge_write", -longint'(l_new), W, 0, 0, 0, 0, 1'b1, 15, l_new);

    rand_coefs();
    load_coefs();
    rand_x();
    do_vec("stall", dot(), W + 3, 2, 3, 6, 5, 1'b0, 0, 0);
    rand_x();
    do_vec("after_drop", dot(), W, 0, 0, 0, 0, 1'b0, 0, 0);

    repeat (6) begin
      rand_coefs();
      load_coefs();
      for (int r = 0; r < 3; r++) begin
        rand_x();
        do_vec("random", dot(), W, 0, 0, 0, 0, 1'b0, 0, 0);
      end
    end

    // Reset while the bit index is at 4
    rand_x();
    for (int k = 0; k < N; k++) x_in[k*W +: W] = x_v[k][W-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_valid_async", out_valid, 0);
    ovr = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) ovr = 1;
    end
    check("midrun_valid_never", ovr, 0);
    rst_n = 1'b1;
    rand_x();
    do_vec("post_rst_lut_lost", 0, W, 0, 0, 0, 0, 1'b0, 0, 0);
    rand_coefs();
    load_coefs();
    rand_x();
    do_vec("post_rst_reload", dot(), W, 0, 0, 0, 0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
